// File: rtl/counter_timer_ctrl.sv
// rtl/counter_timer_ctrl.sv - interval timer sequencer driving a loadable up-counter
// Optional pause input enabled by defining COUNTER_TIMER_CTRL_PAUSE_EN.
module counter_timer_ctrl #(
  parameter int                   DATA_BITS = 8,
  parameter logic [DATA_BITS-1:0] MAX_VALUE = 8'hFF,
  parameter int                   PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [DATA_BITS-1:0] cfg_preload,
  input  logic                 cfg_periodic,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 irq_ack,
`ifdef COUNTER_TIMER_CTRL_PAUSE_EN
  input  logic                 pause,
`endif
  input  logic                 ctr_carry,
  output logic [DATA_BITS-1:0] ctr_data,
  output logic                 ctr_clear,
  output logic                 ctr_load,
  output logic                 ctr_count,
  output logic                 busy,
  output logic                 expired,
  output logic                 irq
);

  // A prescale below one is meaningless; treat it as one.
  localparam int LP_PSC = (PRESCALE < 1) ? 1 : PRESCALE;
  localparam int LP_PW  = (LP_PSC > 1) ? $clog2(LP_PSC) : 1;
  localparam logic [LP_PW-1:0] LP_PSC_LAST = LP_PW'(LP_PSC - 1);

  // The terminal count lives in the counter and reaches us only through
  // ctr_carry; a zero terminal count would make every count pulse an expiry.
  if (MAX_VALUE == '0) begin : g_max_is_zero
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DATA_BITS-1:0] r_preload;
  logic                 r_periodic;
  logic [LP_PW-1:0]     r_presc;
  logic                 r_expired;
  logic                 r_irq;
  logic                 w_pause;
  logic                 w_tick;
  logic                 w_expire;

`ifdef COUNTER_TIMER_CTRL_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // One counter increment per prescaler wrap while running and not frozen.
  assign w_tick   = (r_state == S_RUN) && (r_presc == LP_PSC_LAST) && !w_pause;
  // A stop in the same cycle suppresses the expiry entirely.
  assign w_expire = w_tick && ctr_carry && !stop;

  assign ctr_data = r_preload;
  assign busy     = (r_state != S_IDLE);
  assign expired  = r_expired;
  assign irq      = r_irq;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and counter control strobes.
  always_comb begin
    w_next    = r_state;
    ctr_load  = 1'b0;
    ctr_clear = 1'b0;
    ctr_count = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_next = S_LOAD;
      end
      S_LOAD: begin
        ctr_load = 1'b1;
        w_next   = stop ? S_CLEAR : S_RUN;
      end
      S_RUN: begin
        ctr_count = w_tick;
        if (stop)          w_next = S_CLEAR;
        else if (w_expire) w_next = r_periodic ? S_LOAD : S_CLEAR;
      end
      S_CLEAR: begin
        ctr_clear = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Configuration is only writable while the timer is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_preload  <= '0;
      r_periodic <= 1'b0;
    end else if ((r_state == S_IDLE) && cfg_we) begin
      r_preload  <= cfg_preload;
      r_periodic <= cfg_periodic;
    end
  end

  // Prescaler restarts on every load and holds while paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (r_state == S_LOAD) begin
      r_presc <= '0;
    end else if ((r_state == S_RUN) && !w_pause) begin
      if (r_presc == LP_PSC_LAST) r_presc <= '0;
      else                        r_presc <= r_presc + LP_PW'(1);
    end
  end

  // Expiry pulse and sticky interrupt; a new expiry beats a simultaneous ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_expired <= w_expire;
      if (w_expire)     r_irq <= 1'b1;
      else if (irq_ack) r_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// tb/tb_counter_timer_ctrl.sv - bench for counter_timer_ctrl with PRESCALE 1 and 4 instances
module tb_counter_timer_ctrl;

  localparam int BIG = 32'h3FFF_FFFF;

  logic            clk;
  logic            rst;
  logic            cfg_we;
  logic [7:0]      cfg_preload;
  logic            cfg_periodic;
  logic            start;
  logic            stop;
  logic            irq_ack;
`ifdef COUNTER_TIMER_CTRL_PAUSE_EN
  logic            pause;
`endif
  logic [1:0]      ctr_carry;
  logic [1:0][7:0] ctr_data;
  logic [1:0]      ctr_clear;
  logic [1:0]      ctr_load;
  logic [1:0]      ctr_count;
  logic [1:0]      busy;
  logic [1:0]      expired;
  logic [1:0]      irq;

  logic [7:0] pl_m  [2];
  logic       per_m [2];
  logic       irq_m [2];
  int         n_pass;
  int         n_total;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [7:0] r_cnt;

    counter_timer_ctrl #(
      .DATA_BITS(8),
      .MAX_VALUE(8'hFF),
      .PRESCALE ((g == 0) ? 1 : 4)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_preload (cfg_preload),
      .cfg_periodic(cfg_periodic),
      .start       (start),
      .stop        (stop),
      .irq_ack     (irq_ack),
`ifdef COUNTER_TIMER_CTRL_PAUSE_EN
      .pause       (pause),
`endif
      .ctr_carry   (ctr_carry[g]),
      .ctr_data    (ctr_data[g]),
      .ctr_clear   (ctr_clear[g]),
      .ctr_load    (ctr_load[g]),
      .ctr_count   (ctr_count[g]),
      .busy        (busy[g]),
      .expired     (expired[g]),
      .irq         (irq[g])
    );

    always_ff @(posedge clk) begin
      if (rst)               r_cnt <= 8'h00;
      else if (ctr_clear[g]) r_cnt <= 8'h00;
      else if (ctr_load[g])  r_cnt <= ctr_data[g];
      else if (ctr_count[g]) r_cnt <= r_cnt + 8'h01;
    end

    assign ctr_carry[g] = ctr_count[g] && (r_cnt == 8'hFF);
  end

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  function automatic int psc(input int g);
    return (g == 0) ? 1 : 4;
  endfunction

  // Expected {busy, load, count, clear, expired} after edge t of a run started at edge 0.
  // tp is the expiry period (count pulses * prescale + 1), s the edge where stop takes effect.
  function automatic logic [4:0] expect_out(input int t, input int tp, input int p,
                                            input logic per, input int s);
    int r;
    if (t > s)                 return 5'b00000;
    if (t == s)                return 5'b10010;
    if (!per && t > tp)        return 5'b00000;
    if (!per && t == tp)       return 5'b10011;
    r = per ? (t % tp) : t;
    if (r == 0)                return {2'b11, 2'b00, (t > 0)};
    return {1'b1, 1'b0, ((r % p) == 0), 2'b00};
  endfunction

  task automatic chk(input string tag, input int g, input int t,
                     input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s inst%0d t=%0d observed=%0h expected=%0h", tag, g, t, obs, exp_v);
  endtask

  task automatic check_inst(input int g, input int t, input logic [4:0] e);
    chk("busy",    g, t, {7'd0, busy[g]},      {7'd0, e[4]});
    chk("load",    g, t, {7'd0, ctr_load[g]},  {7'd0, e[3]});
    chk("count",   g, t, {7'd0, ctr_count[g]}, {7'd0, e[2]});
    chk("clear",   g, t, {7'd0, ctr_clear[g]}, {7'd0, e[1]});
    chk("expired", g, t, {7'd0, expired[g]},   {7'd0, e[0]});
    chk("irq",     g, t, {7'd0, irq[g]},       {7'd0, irq_m[g]});
    chk("data",    g, t, ctr_data[g],          pl_m[g]);
  endtask

  task automatic do_cfg(input logic [7:0] pl, input logic per);
    @(negedge clk);
    cfg_we       = 1'b1;
    cfg_preload  = pl;
    cfg_periodic = per;
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      pl_m[g]  = pl;
      per_m[g] = per;
    end
    #1 cfg_we = 1'b0;
  endtask

  // stop_req: 0 = no stop (forced random if any instance is periodic), -1 = random, >0 = that edge.
  task automatic do_run(input logic [7:0] pl, input logic per, input logic wr_cfg, input int stop_req);
    int         tp [2];
    int         se [2];
    logic       rper [2];
    logic [4:0] e  [2];
    logic [4:0] ep [2];
    int         s;
    int         w;
    int         tmax;
    logic       ack_n, start_n, cfg_n, cper;
    logic [7:0] cpl;
    if (wr_cfg) do_cfg(pl, per);
    tmax = 0;
    for (int g = 0; g < 2; g++) begin
      tp[g]   = (256 - int'(pl_m[g])) * psc(g) + 1;
      rper[g] = per_m[g];
      if (tp[g] > tmax) tmax = tp[g];
    end
    s = stop_req;
    if (s < 0 || (s == 0 && (rper[0] || rper[1]))) s = int'($urandom_range(1, 2 * tmax));
    w = 0;
    for (int g = 0; g < 2; g++) begin
      se[g] = (s > 0 && (rper[g] || s <= tp[g])) ? s : BIG;
      if (se[g] != BIG) begin
        if (se[g] + 1 > w) w = se[g] + 1;
      end else begin
        if (tp[g] + 1 > w) w = tp[g] + 1;
      end
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int g = 0; g < 2; g++) begin
      e[g] = expect_out(0, tp[g], psc(g), rper[g], se[g]);
      check_inst(g, 0, e[g]);
    end
    for (int t = 1; t <= w; t++) begin
      ep      = e;
      ack_n   = ($urandom_range(0, 3) == 0);
      start_n = ep[0][4] && ep[1][4] && ($urandom_range(0, 7) == 0);
      cfg_n   = ($urandom_range(0, 5) == 0);
      cper    = 1'($urandom_range(0, 1));
      if (ep[0][4] && ep[1][4]) cpl = 8'($urandom_range(0, 255));
      else                      cpl = {4'hF, 4'($urandom_range(0, 15))};
      irq_ack      = ack_n;
      stop         = (t == s);
      start        = start_n;
      cfg_we       = cfg_n;
      cfg_preload  = cpl;
      cfg_periodic = cper;
      for (int g = 0; g < 2; g++) begin
        e[g] = expect_out(t, tp[g], psc(g), rper[g], se[g]);
        if (cfg_n && !ep[g][4]) begin
          pl_m[g]  = cpl;
          per_m[g] = cper;
        end
        if (e[g][0])    irq_m[g] = 1'b1;
        else if (ack_n) irq_m[g] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) check_inst(g, t, e[g]);
    end
    irq_ack = 1'b0;
    stop    = 1'b0;
    start   = 1'b0;
    cfg_we  = 1'b0;
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    cfg_we       = 1'b0;
    cfg_preload  = 8'h00;
    cfg_periodic = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    irq_ack      = 1'b0;
`ifdef COUNTER_TIMER_CTRL_PAUSE_EN
    pause        = 1'b0;
`endif
    n_pass       = 0;
    n_total      = 0;
    for (int g = 0; g < 2; g++) begin
      pl_m[g]  = 8'h00;
      per_m[g] = 1'b0;
      irq_m[g] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) check_inst(g, -1, 5'b00000);
    rst = 1'b0;

    do_run(8'hF0, 1'b0, 1'b1, 0);
    do_run(8'hF0, 1'b1, 1'b1, 60);
    do_run(8'hFE, 1'b0, 1'b1, 0);
    do_run(8'hF0, 1'b0, 1'b1, 17);
    do_run(8'hF8, 1'b0, 1'b1, 0);
    do_run(8'h00, 1'b1, 1'b0, 0);

    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int g = 0; g < 2; g++) chk("start_stop_idle", g, 0, {7'd0, busy[g]}, 8'h00);
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) chk("start_stop_idle", g, 1, {7'd0, busy[g]}, 8'h00);

`ifdef COUNTER_TIMER_CTRL_PAUSE_EN
    begin
      int first [2];
      first = '{-1, -1};
      do_cfg(8'hF0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int t = 1; t <= 200; t++) begin
        pause = (t >= 3 && t <= 12);
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) if (expired[g] && first[g] < 0) first[g] = t;
      end
      pause = 1'b0;
      chk("pause_expiry", 0, 0, 8'(first[0]), 8'd27);
      chk("pause_expiry", 1, 0, 8'(first[1]), 8'd75);
      for (int g = 0; g < 2; g++) irq_m[g] = 1'b1;
    end
`endif

    do_cfg(8'hF0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      pl_m[g]  = 8'h00;
      per_m[g] = 1'b0;
      irq_m[g] = 1'b0;
      check_inst(g, -2, 5'b00000);
    end

    for (int k = 0; k < 16; k++) begin
      do_run(8'hFF - 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             (k == 0) || ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0) ? -1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
